// File: rtl/smoldvi_pkg.sv
// Shared helpers for the smoldvi gearbox family: level counter sizing and
// buffer capacity legality.
package smoldvi_pkg;

    // A level must count from 0 up to and including the full capacity.
    function automatic int level_width(input int cap);
        return $clog2(cap + 1);
    endfunction

    // The buffer must hold a full input word on top of a not-yet-complete output word.
    function automatic bit cap_legal(input int w_in, input int w_out, input int cap);
        return (w_in >= 1) && (w_out >= 1) && (cap >= w_in + w_out - 1);
    endfunction

endpackage

// File: rtl/smoldvi_stream_gearbox.sv
// Width-converting stream gearbox: W_IN-bit words in, W_OUT-bit words out, LSB first.
// Optional zero-pad flush of a partial output word under SMOLDVI_GEARBOX_FLUSH_EN.
module smoldvi_stream_gearbox
    import smoldvi_pkg::*;
#(
    parameter int W_IN  = 10,
    parameter int W_OUT = 2,
    parameter int CAP   = W_IN + W_OUT
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SMOLDVI_GEARBOX_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] dout,
    output logic             idle
);

    localparam int LW = level_width(CAP);
    localparam logic [LW-1:0] IN_MAX  = LW'(CAP - W_IN);
    localparam logic [LW-1:0] W_IN_L  = LW'(W_IN);
    localparam logic [LW-1:0] W_OUT_L = LW'(W_OUT);

    if (!cap_legal(W_IN, W_OUT, CAP)) begin : g_bad_cap
        $error("smoldvi_stream_gearbox: CAP too small for W_IN/W_OUT");
    end

    logic [CAP-1:0] buf_q, buf_d;
    logic [LW-1:0]  level_q, level_d;
    logic           in_fire, out_fire;

    // Handshake outputs decode the level register only, so neither side's
    // valid/ready can ripple combinationally into the other.
    assign in_ready  = (level_q <= IN_MAX);
    assign out_valid = (level_q >= W_OUT_L);
    assign dout      = buf_q[W_OUT-1:0];
    assign idle      = (level_q == '0);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        // NOTE: blocking assignments here let the input write see the level
        // already reduced by a same-cycle output, with defaults first so no latch forms.
        buf_d   = buf_q;
        level_d = level_q;
        if (out_fire) begin
            buf_d   = buf_q >> W_OUT;
            level_d = level_q - W_OUT_L;
        end
        if (in_fire) begin
            buf_d   = buf_d | (CAP'(din) << level_d);
            level_d = level_d + W_IN_L;
        end
`ifdef SMOLDVI_GEARBOX_FLUSH_EN
        // Bits above the level are always zero, so raising the level pads the word.
        if (flush && !in_fire && !out_fire && level_q != '0 && level_q < W_OUT_L) begin
            level_d = W_OUT_L;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is cleared too, not just the level, because the
            // input merge ORs into it and relies on zeros above the level.
            buf_q   <= '0;
            level_q <= '0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
        end
    end

endmodule

// File: tb/tb_smoldvi_stream_gearbox.sv
// Self-checking bench for smoldvi_stream_gearbox: directed width cases, a random
// bitstream against a bit-queue model, backpressure, reset and optional flush.
module tb_smoldvi_stream_gearbox;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic no_flush = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A: 10 -> 2, default capacity
    logic a_iv = 0, a_ir, a_ov, a_or = 0, a_idle;
    logic [9:0] a_din = '0;
    logic [1:0] a_dout;
    smoldvi_stream_gearbox #(.W_IN(10), .W_OUT(2)) u_a (
        .clk(clk), .rst(rst),
`ifdef SMOLDVI_GEARBOX_FLUSH_EN
        .flush(no_flush),
`endif
        .in_valid(a_iv), .in_ready(a_ir), .din(a_din),
        .out_valid(a_ov), .out_ready(a_or), .dout(a_dout), .idle(a_idle));

    // B: 2 -> 10, default capacity
    logic b_iv = 0, b_ir, b_ov, b_or = 0, b_idle;
    logic [1:0] b_din = '0;
    logic [9:0] b_dout;
    smoldvi_stream_gearbox #(.W_IN(2), .W_OUT(10)) u_b (
        .clk(clk), .rst(rst),
`ifdef SMOLDVI_GEARBOX_FLUSH_EN
        .flush(no_flush),
`endif
        .in_valid(b_iv), .in_ready(b_ir), .din(b_din),
        .out_valid(b_ov), .out_ready(b_or), .dout(b_dout), .idle(b_idle));

    // C: 3 -> 2; capacity 6 so an input and an output can overlap every cycle
    localparam int C_CAP = 6;
    logic c_iv = 0, c_ir, c_ov, c_or = 0, c_idle;
    logic [2:0] c_din = '0;
    logic [1:0] c_dout;
    smoldvi_stream_gearbox #(.W_IN(3), .W_OUT(2), .CAP(C_CAP)) u_c (
        .clk(clk), .rst(rst),
`ifdef SMOLDVI_GEARBOX_FLUSH_EN
        .flush(no_flush),
`endif
        .in_valid(c_iv), .in_ready(c_ir), .din(c_din),
        .out_valid(c_ov), .out_ready(c_or), .dout(c_dout), .idle(c_idle));

    // D: 10 -> 2 with capacity 12, used for output backpressure
    logic d_iv = 0, d_ir, d_ov, d_or = 0, d_idle;
    logic [9:0] d_din = '0;
    logic [1:0] d_dout;
    smoldvi_stream_gearbox #(.W_IN(10), .W_OUT(2), .CAP(12)) u_d (
        .clk(clk), .rst(rst),
`ifdef SMOLDVI_GEARBOX_FLUSH_EN
        .flush(no_flush),
`endif
        .in_valid(d_iv), .in_ready(d_ir), .din(d_din),
        .out_valid(d_ov), .out_ready(d_or), .dout(d_dout), .idle(d_idle));

`ifdef SMOLDVI_GEARBOX_FLUSH_EN
    // E: 3 -> 8 with flush
    logic e_iv = 0, e_ir, e_ov, e_or = 0, e_idle, e_flush = 0;
    logic [2:0] e_din = '0;
    logic [7:0] e_dout;
    smoldvi_stream_gearbox #(.W_IN(3), .W_OUT(8)) u_e (
        .clk(clk), .rst(rst), .flush(e_flush),
        .in_valid(e_iv), .in_ready(e_ir), .din(e_din),
        .out_valid(e_ov), .out_ready(e_or), .dout(e_dout), .idle(e_idle));
`endif

    // Reference model for C: the stream as a queue of bits, oldest at the front.
    bit c_q[$];
    int c_sent = 0;
    bit c_fired;

    // One cycle on C: check handshake state against the model, drive new inputs,
    // and account for whatever fires on the coming edge.
    task automatic c_step(input bit iv, input bit ordy);
        logic [1:0] exp;
        @(negedge clk);
        check("c_in_ready", c_ir, c_q.size() <= C_CAP - 3);
        check("c_out_valid", c_ov, c_q.size() >= 2);
        c_iv  = iv;
        c_or  = ordy;
        c_din = 3'($urandom);
        c_fired = c_ov && ordy;
        if (c_fired && c_q.size() >= 2) begin
            exp[0] = c_q.pop_front();
            exp[1] = c_q.pop_front();
            check("c_dout", c_dout, exp);
        end
        if (c_ir && iv) begin
            for (int i = 0; i < 3; i++) c_q.push_back(c_din[i]);
            c_sent++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] word;
        logic [9:0] exp10;
        logic [1:0] w2 [5];
        int win, fires, cyc;
        bit started;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_a_in_ready", a_ir, 1);
        check("rst_a_out_valid", a_ov, 0);
        check("rst_a_dout", a_dout, 0);
        check("rst_a_idle", a_idle, 1);
        check("rst_b_dout", b_dout, 0);
        check("rst_d_idle", d_idle, 1);

        // ---- 10 -> 2: one word out as five pairs, LSB first ----
        @(negedge clk);
        word = 10'h3A5;
        a_din = word; a_iv = 1; a_or = 1;
        check("a_in_ready", a_ir, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_iv = 0;
            check("a_out_valid", a_ov, 1);
            check("a_dout", a_dout, (word >> (2 * i)) & 10'h3);
        end
        @(negedge clk);
        check("a_idle_end", a_idle, 1);
        check("a_out_valid_end", a_ov, 0);
        a_or = 0;

        // ---- 2 -> 10: five pairs assemble one word ----
        w2[0] = 2'b01; w2[1] = 2'b01; w2[2] = 2'b10; w2[3] = 2'b10; w2[4] = 2'b11;
        b_or = 1;
        exp10 = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b_in_ready", b_ir, 1);
            check("b_no_valid_early", b_ov, 0);
            b_din = w2[k]; b_iv = 1;
            exp10 = exp10 | (10'(w2[k]) << (2 * k));
        end
        @(negedge clk);
        b_iv = 0;
        check("b_out_valid", b_ov, 1);
        check("b_dout", b_dout, exp10);
        check("b_dout_3a5", b_dout, 10'h3A5);
        @(negedge clk);
        check("b_idle", b_idle, 1);
        b_or = 0;

        // ---- 3 -> 2 random stream, both sides always ready ----
        win = 0; fires = 0; cyc = 0; started = 0;
        while (c_sent < 200 && cyc < 2000) begin
            c_step(1, 1);
            cyc++;
            if (started) begin
                win++;
                if (c_fired) fires++;
            end
            if (c_ov) started = 1;
        end
        check("c_sent_in_budget", c_sent, 200);
        check("c_throughput_95pct", (fires * 100 >= win * 95), 1);
        cyc = 0;
        while (c_q.size() >= 2 && cyc < 100) begin
            c_step(0, 1);
            cyc++;
        end
        check("c_drain_in_budget", c_q.size() < 2, 1);

        // ---- 3 -> 2 random stream with random backpressure on both sides ----
        for (int n = 0; n < 400; n++) c_step(1'($urandom), 1'($urandom));
        cyc = 0;
        while (c_q.size() >= 2 && cyc < 100) begin
            c_step(0, 1);
            cyc++;
        end
        c_step(0, 0);
        check("c_idle_after_drain", c_idle, c_q.size() == 0);

        // ---- 10 -> 2, capacity 12, output stalled ----
        word = 10'($urandom);
        @(negedge clk);
        d_din = word; d_iv = 1; d_or = 0;
        check("d_in_ready_first", d_ir, 1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            d_din = ~word;
            check("d_stall_in_ready", d_ir, 0);
            check("d_stall_out_valid", d_ov, 1);
            check("d_stall_dout", d_dout, word[1:0]);
        end
        @(negedge clk);
        d_iv = 0; d_or = 1;
        for (int i = 0; i < 5; i++) begin
            check("d_out_valid", d_ov, 1);
            check("d_dout", d_dout, (word >> (2 * i)) & 10'h3);
            @(negedge clk);
        end
        check("d_idle", d_idle, 1);
        d_or = 0;

`ifdef SMOLDVI_GEARBOX_FLUSH_EN
        // ---- 3 -> 8 flush of a partial word ----
        @(negedge clk);
        e_din = 3'b101; e_iv = 1;
        @(negedge clk);
        e_iv = 0;
        check("e_partial_no_valid", e_ov, 0);
        check("e_partial_not_idle", e_idle, 0);
        e_flush = 1;
        @(negedge clk);
        check("e_flush_valid", e_ov, 1);
        check("e_flush_dout", e_dout, 8'h05);
        e_flush = 0; e_or = 1;
        @(negedge clk);
        check("e_flush_idle", e_idle, 1);
        e_or = 0;
`endif

        // ---- reset mid-stream on 2 -> 10 with six bits buffered ----
        b_or = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b_din = 2'($urandom) | 2'b01; b_iv = 1;
        end
        @(negedge clk);
        check("b_pre_rst_busy", b_idle, 0);
        rst = 1; b_din = 2'b11; b_iv = 1;
        @(negedge clk);
        rst = 0; b_iv = 0;
        check("b_rst_out_valid", b_ov, 0);
        check("b_rst_idle", b_idle, 1);
        check("b_rst_in_ready", b_ir, 1);
        exp10 = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            b_din = 2'($urandom); b_iv = 1;
            exp10 = exp10 | (10'(b_din) << (2 * k));
        end
        @(negedge clk);
        b_iv = 0;
        check("b_post_rst_valid", b_ov, 1);
        check("b_post_rst_dout", b_dout, exp10);
        @(negedge clk);
        check("b_post_rst_idle", b_idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
